run_ctrl: RTL and testbench

- Program-run controller and performance-counter block for the processor top level.
- Owns the Start/Ack handshake: holds the core in reset-like init while Start is high, counts cycles while the program runs, and raises Ack on halt.
- Generalises the single cycle counter to NUM_EV parametrised event counters (instructions, taken branches, loads, stores, …) with a muxed readout port for the testbench and debug logic.

---
 rtl/run_ctrl_if.sv | 29 ++
 rtl/run_ctrl.sv | 119 +++++++++++
 tb/tb_run_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/run_ctrl_if.sv
// Program-run handshake and counter readout bundle for run_ctrl.
// The master side (testbench / processor top) drives Start, Halt, Event and RdSel;
// the slave side (run_ctrl) returns the status flags and counter values.
interface run_ctrl_if #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned NUM_EV = 4,
  parameter int unsigned SEL_W  = 4
);
  logic              Start;
  logic              Halt;
  logic [NUM_EV-1:0] Event;
  logic [SEL_W-1:0]  RdSel;
  logic              CoreInit;
  logic              Running;
  logic              Ack;
  logic              TimedOut;
  logic [CNT_W-1:0]  CycleCt;
  logic [CNT_W-1:0]  RdData;

  modport master (
    output Start, Halt, Event, RdSel,
    input  CoreInit, Running, Ack, TimedOut, CycleCt, RdData
  );

  modport slave (
    input  Start, Halt, Event, RdSel,
    output CoreInit, Running, Ack, TimedOut, CycleCt, RdData
  );
endinterface

// File: rtl/run_ctrl.sv
// Program-run controller with saturating cycle and event counters.
// Start high arms the core (CoreInit held); the first cycle with Start low begins
// the run; Halt ends it and raises Ack. Counters are readable through RdSel/RdData.
// Optional watchdog: define RUN_TIMEOUT_EN to end a run after MAX_CYCLES cycles.
module run_ctrl #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned NUM_EV     = 4,
  parameter int unsigned SEL_W      = 4,
  parameter int unsigned MAX_CYCLES = 16'hFFFF
) (
  input logic       Clk,
  input logic       Reset,
  run_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             running_q, ack_q;
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] ev_q [NUM_EV];
  logic [CNT_W-1:0] rd_data;
  logic             timeout;
  logic             clr;
  logic             cnt_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

`ifdef RUN_TIMEOUT_EN
  logic timed_out_q;

  // Watchdog fires only when neither Start nor Halt claims this cycle.
  assign timeout = (state_q == RUN) && !bus.Start && !bus.Halt &&
                   (cyc_q == CNT_W'(MAX_CYCLES));

  // Sticky timeout flag, cleared when a new run is armed.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      timed_out_q <= 1'b0;
    end else if (state_d == ARM) begin
      timed_out_q <= 1'b0;
    end else if (timeout) begin
      timed_out_q <= 1'b1;
    end
  end

  assign bus.TimedOut = timed_out_q;
`else
  assign timeout      = 1'b0;
  assign bus.TimedOut = 1'b0;
`endif

  // Next-state decode; Start in RUN aborts even when Halt is also high.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.Start) state_d = ARM;
      ARM:  if (!bus.Start) state_d = RUN;
      RUN: begin
        if (bus.Start)     state_d = ARM;
        else if (bus.Halt) state_d = DONE;
        else if (timeout)  state_d = DONE;
      end
      DONE: if (bus.Start) state_d = ARM;
      default: state_d = IDLE;
    endcase
  end

  // Clear while armed or on entry to ARM; count every RUN cycle that does not abort.
  assign clr    = (state_q == ARM) || (state_d == ARM);
  assign cnt_en = (state_q == RUN) && !timeout;

  // State and registered status flags.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == RUN);
      ack_q     <= (state_d == DONE);
    end
  end

  // Saturating cycle and event counters.
  always_ff @(posedge Clk) begin
    if (Reset || clr) begin
      cyc_q <= '0;
      for (int unsigned i = 0; i < NUM_EV; i++) ev_q[i] <= '0;
    end else if (cnt_en) begin
      cyc_q <= sat_inc(cyc_q);
      for (int unsigned i = 0; i < NUM_EV; i++) begin
        if (bus.Event[i]) ev_q[i] <= sat_inc(ev_q[i]);
      end
    end
  end

  // Readout mux: 0 selects the cycle counter, i+1 selects event counter i.
  always_comb begin
    rd_data = '0;
    if (bus.RdSel == '0) rd_data = cyc_q;
    for (int unsigned i = 0; i < NUM_EV; i++) begin
      if (bus.RdSel == SEL_W'(i + 1)) rd_data = ev_q[i];
    end
  end

  assign bus.CoreInit = (state_q == IDLE) || (state_q == ARM);
  assign bus.Running  = running_q;
  assign bus.Ack      = ack_q;
  assign bus.CycleCt  = cyc_q;
  assign bus.RdData   = rd_data;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: a per-cycle vector table for the basic run,
// then hand-written sequences for saturation, abort, reset mid-run and watchdog.
module tb_run_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       start, halt;
  logic [3:0] ev, sel;
  int         total = 0;
  int         bad   = 0;

  always #5 Clk = ~Clk;

  run_ctrl_if #(.CNT_W(16), .NUM_EV(4), .SEL_W(4)) bus_m ();
  run_ctrl_if #(.CNT_W(4),  .NUM_EV(4), .SEL_W(4)) bus_s ();

  assign bus_m.Start = start;
  assign bus_m.Halt  = halt;
  assign bus_m.Event = ev;
  assign bus_m.RdSel = sel;
  assign bus_s.Start = start;
  assign bus_s.Halt  = halt;
  assign bus_s.Event = ev;
  assign bus_s.RdSel = sel;

  run_ctrl #(.CNT_W(16), .NUM_EV(4), .SEL_W(4)) u_dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus_m)
  );

  run_ctrl #(.CNT_W(4), .NUM_EV(4), .SEL_W(4)) u_sat (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus_s)
  );

`ifdef RUN_TIMEOUT_EN
  run_ctrl_if #(.CNT_W(16), .NUM_EV(4), .SEL_W(4)) bus_t ();
  assign bus_t.Start = start;
  assign bus_t.Halt  = halt;
  assign bus_t.Event = ev;
  assign bus_t.RdSel = sel;

  run_ctrl #(.CNT_W(16), .NUM_EV(4), .SEL_W(4), .MAX_CYCLES(8)) u_to (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus_t)
  );
`endif

  typedef struct {
    logic        rst;
    logic        start;
    logic        halt;
    logic [3:0]  ev;
    logic [3:0]  sel;
    logic        init;
    logic        run;
    logic        ack;
    logic [15:0] cyc;
    logic [15:0] rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic s, logic h, logic [3:0] e, logic [3:0] rs,
                              logic i, logic ru, logic a, logic [15:0] c, logic [15:0] d);
    vec_t v;
    v.rst = r; v.start = s; v.halt = h; v.ev = e; v.sel = rs;
    v.init = i; v.run = ru; v.ack = a; v.cyc = c; v.rd = d;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  int sel_list [8] = '{1, 2, 3, 4, 9, 5, 0, 15};
  int rd_list  [8] = '{10, 0, 10, 0, 0, 0, 10, 0};

  initial begin
    Reset = 1'b1; start = 1'b0; halt = 1'b0; ev = 4'h0; sel = 4'h0;

    // Reset, arm for 3 cycles, run 10 cycles with Event=0101, halt on the 10th.
    tbl.push_back(mk(1, 0, 0, 4'h0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'h0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'hF, 1, 1, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 1, 0, 4'hF, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'h5, 1, 0, 1, 0, 0, 0));
    for (int k = 1; k <= 9; k++)
      tbl.push_back(mk(0, 0, 0, 4'h5, 1, 0, 1, 0, 16'(k), 16'(k)));
    tbl.push_back(mk(0, 0, 1, 4'h5, 1, 0, 0, 1, 10, 10));
    // DONE: counters frozen despite Halt/Event, readout over every select.
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(0, 0, 1, 4'hF, 4'(sel_list[k]), 0, 0, 1, 10, 16'(rd_list[k])));

    foreach (tbl[n]) begin
      Reset = tbl[n].rst; start = tbl[n].start; halt = tbl[n].halt;
      ev = tbl[n].ev; sel = tbl[n].sel;
      step();
      chk($sformatf("row%0d_init", n), bus_m.CoreInit, tbl[n].init);
      chk($sformatf("row%0d_run", n), bus_m.Running, tbl[n].run);
      chk($sformatf("row%0d_ack", n), bus_m.Ack, tbl[n].ack);
      chk($sformatf("row%0d_cyc", n), bus_m.CycleCt, tbl[n].cyc);
      chk($sformatf("row%0d_rd", n), bus_m.RdData, tbl[n].rd);
      chk($sformatf("row%0d_to", n), bus_m.TimedOut, 0);
    end
    halt = 1'b0;

    // 20-cycle run: the 4-bit instance saturates at 15.
    start = 1'b1; ev = 4'h1; sel = 4'd1;
    step();
    chk("sat_arm_cyc", bus_s.CycleCt, 0);
    chk("sat_arm_ack", bus_m.Ack, 0);
    start = 1'b0;
    step();
    repeat (20) step();
    chk("sat_main_cyc", bus_m.CycleCt, 20);
    chk("sat_main_run", bus_m.Running, 1);
    chk("sat_cyc", bus_s.CycleCt, 15);
    chk("sat_ev0", bus_s.RdData, 15);
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("sat_done_cyc", bus_m.CycleCt, 21);
    chk("sat_done_ack", bus_m.Ack, 1);

    // Abort: Start with Halt on RUN cycle 5 returns to ARM with everything cleared.
    start = 1'b1; ev = 4'hF;
    step();
    start = 1'b0;
    step();
    repeat (4) step();
    chk("abort_pre_cyc", bus_m.CycleCt, 4);
    start = 1'b1; halt = 1'b1;
    step();
    halt = 1'b0;
    chk("abort_ack", bus_m.Ack, 0);
    chk("abort_run", bus_m.Running, 0);
    chk("abort_init", bus_m.CoreInit, 1);
    chk("abort_cyc", bus_m.CycleCt, 0);
    for (int k = 1; k <= 4; k++) begin
      sel = 4'(k);
      #1;
      chk($sformatf("abort_ev%0d", k - 1), bus_m.RdData, 0);
    end
    start = 1'b0; ev = 4'h2;
    step();
    repeat (2) step();
    halt = 1'b1;
    step();
    halt = 1'b0; ev = 4'h0;
    chk("rerun_ack", bus_m.Ack, 1);
    chk("rerun_cyc", bus_m.CycleCt, 3);
    sel = 4'd2;
    #1;
    chk("rerun_ev1", bus_m.RdData, 3);
    sel = 4'd1;
    #1;
    chk("rerun_ev0", bus_m.RdData, 0);

    // Reset in the middle of a run.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    repeat (7) step();
    chk("mid_cyc", bus_m.CycleCt, 7);
    chk("mid_run", bus_m.Running, 1);
    Reset = 1'b1;
    step();
    chk("rst_init", bus_m.CoreInit, 1);
    chk("rst_run", bus_m.Running, 0);
    chk("rst_ack", bus_m.Ack, 0);
    chk("rst_cyc", bus_m.CycleCt, 0);
    Reset = 1'b0;
    step();
    chk("rst_idle_init", bus_m.CoreInit, 1);
    chk("rst_idle_run", bus_m.Running, 0);

`ifdef RUN_TIMEOUT_EN
    // Watchdog at 8 cycles with Halt never raised.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    repeat (8) step();
    chk("to_pre_cyc", bus_t.CycleCt, 8);
    chk("to_pre_run", bus_t.Running, 1);
    chk("to_pre_flag", bus_t.TimedOut, 0);
    step();
    chk("to_ack", bus_t.Ack, 1);
    chk("to_flag", bus_t.TimedOut, 1);
    chk("to_cyc", bus_t.CycleCt, 8);
    chk("to_run", bus_t.Running, 0);
    step();
    chk("to_hold_flag", bus_t.TimedOut, 1);
    chk("to_hold_cyc", bus_t.CycleCt, 8);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("to_clr_flag", bus_t.TimedOut, 0);
    chk("to_clr_ack", bus_t.Ack, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
